// File: rtl/fsm_arbiter_rr_if.sv
// Request/grant bundle between bus agents (master) and fsm_arbiter_rr (slave).
// Widths follow NUM_REQ; the instance parameter must match the arbiter's.
interface fsm_arbiter_rr_if #(
  parameter int NUM_REQ = 4
);
  localparam int ID_W = $clog2(NUM_REQ);

  logic               mode_rr;
  logic [NUM_REQ-1:0] req;
  logic [NUM_REQ-1:0] gnt;
  logic [ID_W-1:0]    gnt_id;
  logic               gnt_valid;
  logic               timeout_pulse;

  modport master (
    output mode_rr, req,
    input  gnt, gnt_id, gnt_valid, timeout_pulse
  );

  modport slave (
    input  mode_rr, req,
    output gnt, gnt_id, gnt_valid, timeout_pulse
  );
endinterface

// File: rtl/fsm_arbiter_rr.sv
// N-requester grant arbiter, fixed-priority or round-robin, with a dead cycle between owners.
// Optional hold-timeout pre-emption enabled by defining FSM_ARBITER_RR_TIMEOUT_EN.
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_IDLE  | no owner; arbitrate on the next edge if any req is set
// ST_GRANT | gnt_id owns the resource until it drops req (or is timed out)
module fsm_arbiter_rr #(
  parameter int NUM_REQ  = 4,
  parameter int MAX_HOLD = 16
) (
  input logic             clock,
  input logic             reset_n,
  fsm_arbiter_rr_if.slave bus
);
  localparam int ID_W = $clog2(NUM_REQ);

  if (NUM_REQ < 2 || NUM_REQ > 16 || MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_param_chk
    $error("fsm_arbiter_rr: NUM_REQ or MAX_HOLD out of range");
  end

  // Two-bit encoding leaves spare codes that recover to IDLE.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'b01,
    ST_GRANT = 2'b10
  } state_e;

  state_e             state_q, state_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [ID_W-1:0]    gnt_id_q, gnt_id_d;
  logic               gnt_valid_q, gnt_valid_d;
  logic [ID_W-1:0]    last_ptr_q, last_ptr_d;

  logic [ID_W-1:0]    fp_win;
  logic [ID_W-1:0]    rr_win;
  logic [ID_W-1:0]    win;
  logic               others_pending;

`ifdef FSM_ARBITER_RR_TIMEOUT_EN
  localparam int HC_W = $clog2(MAX_HOLD + 1);

  logic [HC_W-1:0]    hold_cnt_q, hold_cnt_d;
  logic               timeout_pulse_q, timeout_pulse_d;
`endif

  // Lowest set index wins; scanning downward leaves the lowest hit last.
  always_comb begin
    fp_win = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (bus.req[ID_W'(i)]) fp_win = ID_W'(i);
    end
  end

  // First set index after last_ptr, wrapping; farthest offset checked first.
  always_comb begin
    int idx;
    idx    = 0;
    rr_win = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx = (int'(last_ptr_q) + k) % NUM_REQ;
      if (bus.req[ID_W'(idx)]) rr_win = ID_W'(idx);
    end
  end

  assign win            = bus.mode_rr ? rr_win : fp_win;
  assign others_pending = |(bus.req & ~gnt_q);

  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    gnt_id_d    = gnt_id_q;
    gnt_valid_d = gnt_valid_q;
    last_ptr_d  = last_ptr_q;
`ifdef FSM_ARBITER_RR_TIMEOUT_EN
    hold_cnt_d      = hold_cnt_q;
    timeout_pulse_d = 1'b0;
`endif

    case (state_q)
      ST_IDLE: begin
        if (|bus.req) begin
          state_d     = ST_GRANT;
          gnt_d       = '0;
          gnt_d[win]  = 1'b1;
          gnt_id_d    = win;
          gnt_valid_d = 1'b1;
          last_ptr_d  = win;
`ifdef FSM_ARBITER_RR_TIMEOUT_EN
          hold_cnt_d  = '0;
`endif
        end
      end

      ST_GRANT: begin
        if (!bus.req[gnt_id_q]) begin
          state_d     = ST_IDLE;
          gnt_d       = '0;
          gnt_valid_d = 1'b0;
        end
`ifdef FSM_ARBITER_RR_TIMEOUT_EN
        else if (hold_cnt_q == HC_W'(MAX_HOLD - 1) && others_pending) begin
          // last_ptr keeps the pre-empted owner so round-robin moves past it.
          state_d         = ST_IDLE;
          gnt_d           = '0;
          gnt_valid_d     = 1'b0;
          timeout_pulse_d = 1'b1;
        end else if (hold_cnt_q != HC_W'(MAX_HOLD)) begin
          hold_cnt_d = hold_cnt_q + 1'b1;
        end
`endif
      end

      default: begin
        state_d     = ST_IDLE;
        gnt_d       = '0;
        gnt_id_d    = '0;
        gnt_valid_d = 1'b0;
`ifdef FSM_ARBITER_RR_TIMEOUT_EN
        hold_cnt_d      = '0;
        timeout_pulse_d = 1'b0;
`endif
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      gnt_q       <= '0;
      gnt_id_q    <= '0;
      gnt_valid_q <= 1'b0;
      last_ptr_q  <= ID_W'(NUM_REQ - 1);
`ifdef FSM_ARBITER_RR_TIMEOUT_EN
      hold_cnt_q      <= '0;
      timeout_pulse_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      gnt_id_q    <= gnt_id_d;
      gnt_valid_q <= gnt_valid_d;
      last_ptr_q  <= last_ptr_d;
`ifdef FSM_ARBITER_RR_TIMEOUT_EN
      hold_cnt_q      <= hold_cnt_d;
      timeout_pulse_q <= timeout_pulse_d;
`endif
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.gnt_id    = gnt_id_q;
  assign bus.gnt_valid = gnt_valid_q;
`ifdef FSM_ARBITER_RR_TIMEOUT_EN
  assign bus.timeout_pulse = timeout_pulse_q;
`else
  assign bus.timeout_pulse = 1'b0;
`endif

endmodule

// File: tb/tb_fsm_arbiter_rr.sv
// Bench for fsm_arbiter_rr: 4- and 8-requester instances against a behavioural model,
// directed scenarios followed by randomized request traffic.
`timescale 1ns/1ps
module tb_fsm_arbiter_rr;
  localparam int MH = 4;
`ifdef FSM_ARBITER_RR_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic       clock   = 1'b0;
  logic       reset_n = 1'b1;
  logic       mode    = 1'b1;
  logic [3:0] req4    = '0;
  logic [7:0] req8    = '0;
  int         n_chk   = 0;
  int         n_bad   = 0;

  always #5 clock = ~clock;

  fsm_arbiter_rr_if #(.NUM_REQ(4)) bus4 ();
  fsm_arbiter_rr_if #(.NUM_REQ(8)) bus8 ();

  assign bus4.mode_rr = mode;
  assign bus4.req     = req4;
  assign bus8.mode_rr = mode;
  assign bus8.req     = req8;

  fsm_arbiter_rr #(.NUM_REQ(4), .MAX_HOLD(MH)) u_dut4 (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus4)
  );

  fsm_arbiter_rr #(.NUM_REQ(8), .MAX_HOLD(MH)) u_dut8 (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus8)
  );

  // Model: who owns the resource, who owned it last, and how long it has held.
  typedef struct {
    bit busy;
    int owner;
    int last;
    int hold;
    bit pulse;
  } mdl_t;

  mdl_t m4, m8;

  function automatic mdl_t mdl_reset(int n);
    mdl_t t;
    t.busy  = 1'b0;
    t.owner = 0;
    t.last  = n - 1;
    t.hold  = 0;
    t.pulse = 1'b0;
    return t;
  endfunction

  function automatic mdl_t mdl_step(mdl_t s, logic [15:0] r, bit m, int n);
    mdl_t t;
    t       = s;
    t.pulse = 1'b0;
    if (!s.busy) begin
      if (r != 16'd0) begin
        int w;
        w = -1;
        for (int i = 0; i < n; i++) begin
          int c;
          c = m ? (s.last + 1 + i) % n : i;
          if (w < 0 && r[c]) w = c;
        end
        t.busy  = 1'b1;
        t.owner = w;
        t.last  = w;
        t.hold  = 0;
      end
    end else if (!r[s.owner]) begin
      t.busy = 1'b0;
    end else if (TO_EN && s.hold == MH - 1 && (r & ~(16'(1) << s.owner)) != 16'd0) begin
      t.busy  = 1'b0;
      t.pulse = 1'b1;
    end else if (s.hold < MH) begin
      t.hold = s.hold + 1;
    end
    return t;
  endfunction

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s obs=0x%0h exp=0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_outs();
    check_val("gnt4", 32'(bus4.gnt), m4.busy ? (32'd1 << m4.owner) : 32'd0);
    check_val("id4",  32'(bus4.gnt_id), 32'(m4.owner));
    check_val("vld4", 32'(bus4.gnt_valid), 32'(m4.busy));
    check_val("to4",  32'(bus4.timeout_pulse), 32'(m4.pulse));
    check_val("gnt8", 32'(bus8.gnt), m8.busy ? (32'd1 << m8.owner) : 32'd0);
    check_val("id8",  32'(bus8.gnt_id), 32'(m8.owner));
    check_val("vld8", 32'(bus8.gnt_valid), 32'(m8.busy));
    check_val("to8",  32'(bus8.timeout_pulse), 32'(m8.pulse));
  endtask

  task automatic model_reset();
    m4 = mdl_reset(4);
    m8 = mdl_reset(8);
  endtask

  // One clock: advance the model on the edge, compare 1 ns later.
  task automatic tick();
    @(posedge clock);
    if (!reset_n) begin
      model_reset();
    end else begin
      m4 = mdl_step(m4, 16'(req4), mode, 4);
      m8 = mdl_step(m8, 16'(req8), mode, 8);
    end
    #1;
    check_outs();
  endtask

  initial begin
    model_reset();

    // Reset with all requests raised: no grant.
    mode = 1'b1;
    req4 = 4'hF;
    req8 = 8'hFF;
    #1 reset_n = 1'b0;
    repeat (3) tick();
    check_val("rst_gnt", 32'(bus4.gnt), 32'd0);
    check_val("rst_vld", 32'(bus4.gnt_valid), 32'd0);
    reset_n = 1'b1;
    tick();
    check_val("rst_first_gnt", 32'(bus4.gnt), 32'h1);
    check_val("rst_first_id",  32'(bus4.gnt_id), 32'd0);

    // Round-robin fairness: each owner drops req for one cycle after its grant.
    for (int k = 1; k <= 4; k++) begin
      req4 = 4'hF & ~(4'h1 << ((k - 1) % 4));
      tick();
      check_val("rr_gap", 32'(bus4.gnt), 32'd0);
      req4 = 4'hF;
      tick();
      check_val("rr_order_id",  32'(bus4.gnt_id), 32'(k % 4));
      check_val("rr_order_gnt", 32'(bus4.gnt), 32'd1 << (k % 4));
    end

    // Fixed priority, then handover through a dead cycle.
    mode = 1'b0;
    req4 = 4'h0;
    tick();
    tick();
    req4 = 4'b1100;
    tick();
    check_val("fp_gnt", 32'(bus4.gnt), 32'b0100);
    req4 = 4'b1000;
    tick();
    check_val("fp_dead", 32'(bus4.gnt), 32'd0);
    tick();
    check_val("fp_next_gnt", 32'(bus4.gnt), 32'b1000);
    check_val("fp_next_id",  32'(bus4.gnt_id), 32'd3);

    // Wrap-around: last owner is the top index, the search wraps to 0.
    mode = 1'b1;
    req4 = 4'h0;
    req8 = 8'h00;
    tick();
    tick();
    req4 = 4'h8;
    req8 = 8'h80;
    tick();
    check_val("wrap_own8", 32'(bus8.gnt_id), 32'd7);
    req4 = 4'h0;
    req8 = 8'h00;
    tick();
    req4 = 4'h9;
    req8 = 8'h81;
    tick();
    check_val("wrap_id8", 32'(bus8.gnt_id), 32'd0);
    check_val("wrap_id4", 32'(bus4.gnt_id), 32'd0);

    // Long hold with no competitor: never pre-empted.
    req4 = 4'h0;
    req8 = 8'h00;
    tick();
    tick();
    req4 = 4'b0010;
    tick();
    repeat (MH + 4) tick();
    check_val("hold_gnt",   32'(bus4.gnt), 32'b0010);
    check_val("hold_pulse", 32'(bus4.timeout_pulse), 32'd0);

    // Competitor raised on a fresh grant: pre-empted only with the timeout build.
    req4 = 4'h0;
    tick();
    tick();
    req4 = 4'b0010;
    tick();
    req4 = 4'b1010;
    repeat (MH - 1) tick();
    check_val("to_before", 32'(bus4.gnt), 32'b0010);
    tick();
`ifdef FSM_ARBITER_RR_TIMEOUT_EN
    check_val("to_release", 32'(bus4.gnt), 32'd0);
    check_val("to_pulse",   32'(bus4.timeout_pulse), 32'd1);
`endif
    tick();
`ifdef FSM_ARBITER_RR_TIMEOUT_EN
    check_val("to_next_gnt", 32'(bus4.gnt), 32'b1000);
    check_val("to_pulse_end", 32'(bus4.timeout_pulse), 32'd0);
`endif

    // Async reset mid-grant: grant drops before the next edge.
    req4 = 4'h0;
    tick();
    tick();
    tick();
    req4 = 4'b0010;
    tick();
    check_val("ar_pre_gnt", 32'(bus4.gnt), 32'b0010);
    #3 reset_n = 1'b0;
    #1;
    model_reset();
    check_val("ar_gnt", 32'(bus4.gnt), 32'd0);
    check_val("ar_vld", 32'(bus4.gnt_valid), 32'd0);
    #1 reset_n = 1'b1;
    mode = 1'b1;
    req4 = 4'b0110;
    tick();
    check_val("ar_after_id", 32'(bus4.gnt_id), 32'd1);

    // Random traffic: requests toggle sparsely, mode flips, rare async resets.
    for (int c = 0; c < 4000; c++) begin
      for (int b = 0; b < 4; b++) if ($urandom_range(5) == 0) req4[b] = ~req4[b];
      for (int b = 0; b < 8; b++) if ($urandom_range(5) == 0) req8[b] = ~req8[b];
      if ($urandom_range(19) == 0) mode = ~mode;
      if ($urandom_range(499) == 0) begin
        reset_n = 1'b0;
        #1;
        model_reset();
        check_outs();
        reset_n = 1'b1;
      end
      tick();
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
